// File: rtl/fpu_pkg.sv
// Shared binary32 types and constants for the FPU datapath blocks.
package fpu_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    typedef struct packed {
        logic invalid;
        logic overflow;
        logic underflow;
        logic inexact;
    } fpu_flags_t;

    localparam int          FP32_BIAS    = 127;
    localparam logic [7:0]  FP32_EXP_MAX = 8'hFF;
    localparam logic [31:0] FP32_QNAN    = 32'hFFFF_FFFF;

endpackage

// File: rtl/fpu_round_rne.sv
// Normalises a 48-bit significand product (leading one at bit 47 or 46) and
// rounds it to a 23-bit fraction, round-to-nearest ties-to-even.
module fpu_round_rne (
    input  logic [47:0]       mant,
    input  logic signed [9:0] exp_in,
    output logic [22:0]       frac,
    output logic signed [9:0] exp_out,
    output logic              inexact
);

    logic [47:0]       norm;
    logic signed [9:0] exp_n;
    logic [22:0]       frac_t;
    logic              g, r, s, up;
    logic [23:0]       sum;

    assign norm   = mant[47] ? mant : {mant[46:0], 1'b0};
    assign exp_n  = exp_in + $signed({9'd0, mant[47]});
    assign frac_t = norm[46:24];
    assign g      = norm[23];
    assign r      = norm[22];
    assign s      = |norm[21:0];
    assign up     = g & (r | s | frac_t[0]);
    assign sum    = {1'b0, frac_t} + {23'd0, up};

    // Carry out of an all-ones fraction leaves frac at zero; only the exponent moves.
    assign frac    = sum[22:0];
    assign exp_out = exp_n + $signed({9'd0, sum[23]});
    assign inexact = g | r | s;

endmodule

// File: rtl/fpu_mult_diya.sv
// binary32 multiplier: combinational datapath into one output register stage.
// Subnormal operands and results are flushed to signed zero.
module fpu_mult_diya
    import fpu_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        valid_in,
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    output logic [31:0] result,
    output logic        valid_out,
    output logic        flag_invalid,
    output logic        flag_overflow,
    output logic        flag_underflow,
    output logic        flag_inexact
);

    fp32_t             a, b;
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sign;
    logic [47:0]       prod;
    logic signed [9:0] exp_raw, exp_r;
    logic [22:0]       frac_r;
    logic              rnd_inexact;
    logic [31:0]       res_n;
    fpu_flags_t        flags_n, flags_q;

    assign a      = data1;
    assign b      = data2;
    assign a_nan  = (a.exp == FP32_EXP_MAX) && (a.frac != '0);
    assign b_nan  = (b.exp == FP32_EXP_MAX) && (b.frac != '0);
    assign a_inf  = (a.exp == FP32_EXP_MAX) && (a.frac == '0);
    assign b_inf  = (b.exp == FP32_EXP_MAX) && (b.frac == '0);
    assign a_zero = (a.exp == '0);
    assign b_zero = (b.exp == '0);
    assign sign   = a.sign ^ b.sign;

    assign prod    = 48'({1'b1, a.frac}) * 48'({1'b1, b.frac});
    assign exp_raw = $signed(10'(a.exp)) + $signed(10'(b.exp)) - 10'sd127;

    fpu_round_rne u_round (
        .mant    (prod),
        .exp_in  (exp_raw),
        .frac    (frac_r),
        .exp_out (exp_r),
        .inexact (rnd_inexact)
    );

    always_comb begin
        res_n   = '0;
        flags_n = '0;
        if (a_nan || b_nan) begin
            res_n           = FP32_QNAN;
            flags_n.invalid = 1'b1;
        end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
            res_n           = FP32_QNAN;
            flags_n.invalid = 1'b1;
        end else if (a_inf || b_inf) begin
            res_n = {sign, FP32_EXP_MAX, 23'd0};
        end else if (a_zero || b_zero) begin
            res_n = {sign, 31'd0};
        end else if (exp_r >= 10'sd255) begin
            res_n            = {sign, FP32_EXP_MAX, 23'd0};
            flags_n.overflow = 1'b1;
            flags_n.inexact  = 1'b1;
        end else if (exp_r <= 10'sd0) begin
            res_n             = {sign, 31'd0};
            flags_n.underflow = 1'b1;
            flags_n.inexact   = 1'b1;
        end else begin
            res_n           = {sign, exp_r[7:0], frac_r};
            flags_n.inexact = rnd_inexact;
        end
    end

    // Result and flags hold across idle cycles; only valid_out tracks valid_in.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            result    <= '0;
            flags_q   <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= valid_in;
            if (valid_in) begin
                result  <= res_n;
                flags_q <= flags_n;
            end
        end
    end

    assign flag_invalid   = flags_q.invalid;
    assign flag_overflow  = flags_q.overflow;
    assign flag_underflow = flags_q.underflow;
    assign flag_inexact   = flags_q.inexact;

endmodule

// File: tb/tb_fpu_mult_diya.sv
// Directed-vector bench for fpu_mult_diya with a queue scoreboard and monitor.
module tb_fpu_mult_diya;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [3:0]  f;  // {invalid, overflow, underflow, inexact}
        string       nm;
    } vec_t;

    typedef struct {
        logic [31:0] r;
        logic [3:0]  f;
        string       nm;
    } exp_t;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        valid_in;
    logic [31:0] data1, data2;
    logic [31:0] result;
    logic        valid_out, flag_invalid, flag_overflow, flag_underflow, flag_inexact;
    logic [3:0]  flags_now;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    vec_t vecs[$];

    fpu_mult_diya dut (
        .CLK            (CLK),
        .nRST           (nRST),
        .valid_in       (valid_in),
        .data1          (data1),
        .data2          (data2),
        .result         (result),
        .valid_out      (valid_out),
        .flag_invalid   (flag_invalid),
        .flag_overflow  (flag_overflow),
        .flag_underflow (flag_underflow),
        .flag_inexact   (flag_inexact)
    );

    always #5 CLK = ~CLK;

    assign flags_now = {flag_invalid, flag_overflow, flag_underflow, flag_inexact};

    task automatic check(input string nm, input logic [36:0] act, input logic [36:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    task automatic issue(input vec_t v);
        exp_t e;
        @(negedge CLK);
        valid_in = 1'b1;
        data1    = v.a;
        data2    = v.b;
        e.r  = v.r;
        e.f  = v.f;
        e.nm = v.nm;
        sb.push_back(e);
    endtask

    task automatic idle();
        @(negedge CLK);
        valid_in = 1'b0;
    endtask

    // Monitor: every valid_out pops the oldest expectation.
    always @(posedge CLK) begin
        exp_t e;
        #1;
        if (nRST && valid_out) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid: result %h with empty scoreboard", result);
            end else begin
                e = sb.pop_front();
                check(e.nm, {result, flags_now, valid_out}, {e.r, e.f, 1'b1});
            end
        end
    end

    initial begin
        vecs.push_back('{32'h42C86666, 32'h42B50000, 32'h460DB066, 4'b0001, "100.2x90.5"});
        vecs.push_back('{32'hC0ACCCCD, 32'hC12CCCCD, 32'h426947AF, 4'b0001, "neg_x_neg"});
        vecs.push_back('{32'h40ACCCCD, 32'hC12CCCCD, 32'hC26947AF, 4'b0001, "pos_x_neg"});
        vecs.push_back('{32'hC12CCCCD, 32'h40ACCCCD, 32'hC26947AF, 4'b0001, "neg_x_pos"});
        vecs.push_back('{32'h40ACCCCD, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1000, "x_nan"});
        vecs.push_back('{32'h7F800000, 32'h00000000, 32'hFFFFFFFF, 4'b1000, "inf_x_zero"});
        vecs.push_back('{32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101, "overflow"});
        vecs.push_back('{32'hFF000000, 32'h40000000, 32'hFF800000, 4'b0101, "overflow_neg"});
        vecs.push_back('{32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011, "underflow"});
        vecs.push_back('{32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000, "2x3_exact"});
        vecs.push_back('{32'h7F800000, 32'hC0000000, 32'hFF800000, 4'b0000, "inf_x_neg2"});
        vecs.push_back('{32'h00000000, 32'hC0400000, 32'h80000000, 4'b0000, "zero_x_neg3"});
        vecs.push_back('{32'h00000001, 32'h40000000, 32'h00000000, 4'b0000, "subnormal_in"});
        vecs.push_back('{32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 4'b0000, "max_finite_x1"});
        vecs.push_back('{32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000, "1.5x1.5_carry47"});
        vecs.push_back('{32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 4'b0001, "near2_squared"});

        nRST     = 1'b0;
        valid_in = 1'b0;
        data1    = '0;
        data2    = '0;
        #12;
        check("reset_state", {result, flags_now, valid_out}, 37'd0);
        @(negedge CLK);
        nRST = 1'b1;

        foreach (vecs[i]) issue(vecs[i]);

        // Idle cycle: outputs hold the last product, valid_out drops.
        idle();
        data1 = 32'h3F800000;
        data2 = 32'h3F800000;
        @(posedge CLK);
        #2;
        check("idle_hold", {result, flags_now, valid_out}, {32'h407FFFFE, 4'b0001, 1'b0});

        // Asynchronous reset with a result registered and another operation presented.
        issue(vecs[9]);
        @(posedge CLK);
        #3;
        data1 = 32'h42C86666;
        data2 = 32'h42B50000;
        nRST  = 1'b0;
        #1;
        check("async_reset", {result, flags_now, valid_out}, 37'd0);
        @(posedge CLK);
        #1;
        check("reset_discard", {result, flags_now, valid_out}, 37'd0);
        @(negedge CLK);
        valid_in = 1'b0;
        nRST     = 1'b1;

        issue(vecs[1]);
        issue(vecs[9]);
        issue(vecs[14]);
        idle();

        for (int c = 0; c < 20 && sb.size() != 0; c++) @(posedge CLK);
        #2;
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fpu_mult_diya.md
Name: fpu_mult_diya

Overview:
- IEEE-754 binary32 multiplier for the FPU datapath.
- Combinational sign/exponent/mantissa datapath feeding a single output register stage (latency 1).
- Takes two single-precision operands; produces the rounded product plus exception flags.
- Sits beside the FPU adder; driven by the FPU operand-issue logic.

Parameters:
- none; the format is fixed binary32 (1 sign, 8 exponent, 23 fraction, bias 127).

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- valid_in  input  1  operands on data1/data2 valid this cycle.
- data1  input  32  operand A, binary32.
- data2  input  32  operand B, binary32.
- result  output  32  registered product, binary32.
- valid_out  output  1  result valid; registered copy of valid_in.
- flag_invalid  output  1  NaN operand, or inf x 0.
- flag_overflow  output  1  rounded result exceeded max finite.
- flag_underflow  output  1  nonzero result flushed to zero.
- flag_inexact  output  1  rounding discarded nonzero bits, or overflow/underflow occurred.

Behaviour:
- Reset (nRST low, asynchronous): result=32'h0, valid_out=0, all flags=0. Reset mid-operation discards the in-flight result. The first valid_in sampled after release is processed normally.
- Latency: operands sampled on a CLK edge with valid_in=1 appear on result/flags at that same edge (output registered, input path combinational), i.e. visible one cycle after presentation. Full throughput: one new operation per cycle, no stall.
- valid_in=0: result and flags hold their previous values; valid_out=0.
- Sign: sign = data1[31] XOR data2[31] for all non-NaN results.
- Special cases, checked in priority order:
  - Either operand NaN (exp=FF, frac!=0): result=32'hFFFF_FFFF (canonical NaN), flag_invalid=1.
  - Inf x zero: result=32'hFFFF_FFFF, flag_invalid=1.
  - Inf x finite nonzero: result is signed infinity {sign,8'hFF,23'h0}.
  - Zero x finite: result is signed zero.
- Subnormal inputs (exp=0, frac!=0) are treated as signed zero (flush-to-zero). Subnormal outputs are likewise flushed to signed zero with flag_underflow=1 and flag_inexact=1.
- Normal path:
  - Multiply 24-bit significands (hidden 1) into a 48-bit product.
  - Exponent: E = e1 + e2 - 127, computed with 10-bit signed arithmetic.
  - If product bit 47 is set, shift right 1 and E += 1.
  - Round to nearest, ties to even, using guard, round and sticky bits. A mantissa carry out of rounding renormalises with E += 1.
- Overflow: final E >= 255 gives signed infinity, flag_overflow=1, flag_inexact=1.
- Underflow: final E <= 0 gives signed zero, flag_underflow=1, flag_inexact=1.

Decomposition:
- Shared package fpu_pkg:
  - typedef fp32_t as a struct {sign, exp[7:0], frac[22:0]}.
  - Constants: FP32_BIAS=127, FP32_EXP_MAX=8'hFF, FP32_QNAN=32'hFFFF_FFFF.
  - Flag struct typedef fpu_flags_t.
- One natural sub-module, fpu_round_rne: takes the normalised 48-bit product and exponent; returns the rounded fraction, adjusted exponent and inexact bit. Reusable by the adder.

Test Plan:
- 100.2 x 90.5: data1=32'h42C86666, data2=32'h42B50000, valid_in=1 -> next cycle result=32'h460DB066 (9068.1), valid_out=1, flags=0 except flag_inexact.
- -5.4 x -10.8 (32'hC0ACCCCD, 32'hC12CCCCD) -> result=32'h426947AF (+58.320004).
- 5.4 x -10.8 (32'h40ACCCCD, 32'hC12CCCCD), and -10.8 x 5.4 (32'hC12CCCCD, 32'h40ACCCCD) -> both result=32'hC26947AF (-58.320004).
- 5.4 x NaN (32'h40ACCCCD, 32'hFFFFFFFF) -> result=32'hFFFFFFFF, flag_invalid=1. Also +inf x 0 (32'h7F800000, 32'h0) -> 32'hFFFFFFFF, flag_invalid=1.
- Range limits:
  - 32'h7F000000 x 32'h40000000 -> 32'h7F800000, flag_overflow=1.
  - 32'h00800000 x 32'h3F000000 -> 32'h00000000, flag_underflow=1.
- Reset and throughput:
  - Assert nRST low asynchronously mid-stream -> result=0, valid_out=0 immediately, without waiting for a clock edge.
  - Back-to-back valid_in over 3 cycles -> 3 consecutive correct results, one per cycle.
